// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath constants for the conv2 pooling stage
package cnn_pkg;
  localparam int DW      = 12;
  localparam int CONV2_W = 8;
  localparam int CONV2_H = 8;
  localparam int POOL_W  = CONV2_W / 2;
  localparam int POOL_H  = CONV2_H / 2;
  localparam int NUM_CH  = 3;
endpackage

// File: rtl/relu_max3.sv
// rtl/relu_max3.sv - ReLU of a new pixel plus 3-input unsigned max
module relu_max3 #(
  parameter int DW = cnn_pkg::DW
) (
  input  logic [DW-1:0] pix_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] relu_o,
  output logic [DW-1:0] max_o
);
  logic [DW-1:0] ab;

  assign relu_o = pix_i[DW-1] ? '0 : pix_i;
  assign ab     = (a_i > b_i) ? a_i : b_i;
  assign max_o  = (ab > relu_o) ? ab : relu_o;
endmodule

// File: rtl/maxpool_relu2.sv
// rtl/maxpool_relu2.sv - 2x2 max-pool with ReLU over three conv2 channels
module maxpool_relu2 #(
  parameter int IN_W = cnn_pkg::CONV2_W,
  parameter int IN_H = cnn_pkg::CONV2_H,
  parameter int DW   = cnn_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic [DW-1:0] conv_out_1,
  input  logic [DW-1:0] conv_out_2,
  input  logic [DW-1:0] conv_out_3,
  output logic [DW-1:0] max_value_1,
  output logic [DW-1:0] max_value_2,
  output logic [DW-1:0] max_value_3,
  output logic          valid_out,
  output logic          busy,
  output logic          frame_done
);
  localparam int NCH  = cnn_pkg::NUM_CH;
  localparam int XW   = $clog2(IN_W);
  localparam int YW   = $clog2(IN_H);
  localparam int HALF = IN_W / 2;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          last_x, last_y;

  logic [DW-1:0] pix     [NCH];
  logic [DW-1:0] relu    [NCH];
  logic [DW-1:0] mx      [NCH];
  logic [DW-1:0] sel_row [NCH];
  logic [DW-1:0] hold_q  [NCH];
  logic [DW-1:0] row_q   [NCH][HALF];
  logic [DW-1:0] max_q   [NCH];
  logic          valid_q, done_q;

  assign pix[0] = conv_out_1;
  assign pix[1] = conv_out_2;
  assign pix[2] = conv_out_3;

  assign last_x = (x_q == XW'(IN_W - 1));
  assign last_y = (y_q == YW'(IN_H - 1));
  assign x_d    = last_x ? '0 : x_q + 1'b1;
  assign y_d    = last_x ? (last_y ? '0 : y_q + 1'b1) : y_q;

  // On even rows the row-buffer operand is forced to zero, so the same
  // max3 serves both the half-row write and the final pooled output.
  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    assign sel_row[ch] = y_q[0] ? row_q[ch][x_q[XW-1:1]] : '0;
    relu_max3 #(.DW(DW)) u_relu_max3 (
      .pix_i  (pix[ch]),
      .a_i    (hold_q[ch]),
      .b_i    (sel_row[ch]),
      .relu_o (relu[ch]),
      .max_o  (mx[ch])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        hold_q[ch] <= '0;
        max_q[ch]  <= '0;
        for (int i = 0; i < HALF; i++) row_q[ch][i] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (valid_in) begin
        x_q <= x_d;
        y_q <= y_d;
        for (int ch = 0; ch < NCH; ch++) begin
          if (!x_q[0])      hold_q[ch] <= relu[ch];
          else if (!y_q[0]) row_q[ch][x_q[XW-1:1]] <= mx[ch];
          else              max_q[ch] <= mx[ch];
        end
        if (x_q[0] && y_q[0]) begin
          valid_q <= 1'b1;
          done_q  <= last_x && last_y;
        end
      end
    end
  end

  assign max_value_1 = max_q[0];
  assign max_value_2 = max_q[1];
  assign max_value_3 = max_q[2];
  assign valid_out   = valid_q;
  assign frame_done  = done_q;
  assign busy        = (x_q != '0) || (y_q != '0);
endmodule
